lag_pl_status_tracker: RTL and testbench

- Per-output-port, per-PL bookkeeping stage that produces the free/busy status vector used by the PL allocator.
- Consumes the allocator's per-cycle allocation pulses, the switch's flit-sent events and the downstream credit returns.
- Tracks buffer credits per output PL and releases a PL back to the free pool once its tail flit has left and every downstream buffer slot has been returned.
- Sits beside the allocator in each router: it drives the allocator's status input and receives the allocator's allocation output.

---
 rtl/lag_pl_status_tracker_if.sv | 29 ++
 rtl/lag_pl_status_tracker.sv | 113 +++++++++++
 tb/tb_lag_pl_status_tracker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lag_pl_status_tracker_if.sv
// Allocator/switch/credit-side bundle for one router's PL status tracker.
// Inputs are per-cycle pulses; outputs are the registered per-PL status and credit view.
interface lag_pl_status_tracker_if #(
    parameter int np      = 5,
    parameter int nv      = 4,
    parameter int buf_len = 4
);
    localparam int CW = $clog2(buf_len + 1);

    logic [np-1:0][nv-1:0]         pl_allocated;
    logic [np-1:0]                 flit_sent_valid;
    logic [np-1:0][nv-1:0]         flit_sent_pl;
    logic [np-1:0]                 flit_sent_tail;
    logic [np-1:0][nv-1:0]         credit_in;
    logic [np-1:0][nv-1:0]         pl_alloc_status;
    logic [np-1:0][nv-1:0]         credit_avail;
    logic [np-1:0][nv-1:0][CW-1:0] credit_cnt;
    logic                          error;

    modport master (
        output pl_allocated, flit_sent_valid, flit_sent_pl, flit_sent_tail, credit_in,
        input  pl_alloc_status, credit_avail, credit_cnt, error
    );

    modport slave (
        input  pl_allocated, flit_sent_valid, flit_sent_pl, flit_sent_tail, credit_in,
        output pl_alloc_status, credit_avail, credit_cnt, error
    );
endinterface

// File: rtl/lag_pl_status_tracker.sv
// Per-output-PL credit counter and FREE/ACTIVE/DRAIN tracker feeding the PL allocator,
// with a sticky OR of all protocol violations.
module lag_pl_status_lane #(
    parameter int buf_len = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc,
    input  logic          send,
    input  logic          tail,
    input  logic          credit,
    output logic          status,
    output logic          avail,
    output logic [CW-1:0] cnt,
    output logic          err
);
    typedef enum logic [1:0] {FREE, ACTIVE, DRAIN} state_t;

    localparam logic [CW-1:0] FULL = CW'(buf_len);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          underflow, overflow, drained;

    // A credit can never pair with a flit sent this same cycle, so a credit
    // arriving at a full counter is an overflow even when a send cancels it.
    always_comb begin
        underflow = send & ~credit & (cnt == '0);
        overflow  = credit & (cnt == FULL);
        cnt_nxt   = cnt;
        if (send & ~credit & ~underflow)
            cnt_nxt = cnt - 1'b1;
        else if (credit & ~send & ~overflow)
            cnt_nxt = cnt + 1'b1;
        drained   = (cnt_nxt == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FREE;
            cnt   <= FULL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE:    if (alloc) state_nxt = ACTIVE;
            ACTIVE:  if (tail) state_nxt = drained ? FREE : DRAIN;
            DRAIN:   if (drained) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
    end

    always_comb begin
        status = (state == FREE);
        avail  = (cnt != '0);
        err    = underflow | overflow
               | (send & (state != ACTIVE))
               | (alloc & (state != FREE));
    end
endmodule

module lag_pl_status_tracker #(
    parameter int np      = 5,
    parameter int nv      = 4,
    parameter int buf_len = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    lag_pl_status_tracker_if.slave bus
);
    localparam int CW = $clog2(buf_len + 1);

    logic [np-1:0][nv-1:0] lane_err;
    logic [np-1:0]         multi_hot;
    logic                  error_q;

    for (genvar p = 0; p < np; p++) begin : g_port
        // More than one PL selected on a port is a violation; each is still counted.
        assign multi_hot[p] = bus.flit_sent_valid[p] &
                              ((bus.flit_sent_pl[p] & (bus.flit_sent_pl[p] - 1'b1)) != '0);

        for (genvar v = 0; v < nv; v++) begin : g_pl
            logic send;
            assign send = bus.flit_sent_valid[p] & bus.flit_sent_pl[p][v];

            lag_pl_status_lane #(.buf_len(buf_len), .CW(CW)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .alloc  (bus.pl_allocated[p][v]),
                .send   (send),
                .tail   (send & bus.flit_sent_tail[p]),
                .credit (bus.credit_in[p][v]),
                .status (bus.pl_alloc_status[p][v]),
                .avail  (bus.credit_avail[p][v]),
                .cnt    (bus.credit_cnt[p][v]),
                .err    (lane_err[p][v])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) error_q <= 1'b0;
        else        error_q <= error_q | (|lane_err) | (|multi_hot);
    end

    assign bus.error = error_q;
endmodule

// File: tb/tb_lag_pl_status_tracker.sv
// Scoreboard bench: driver feeds directed + random traffic into a behavioural model,
// a negedge monitor pops the predicted outputs and compares them with the tracker.
module tb_lag_pl_status_tracker;
    localparam int NP = 5, NV = 4, BL = 4, CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lag_pl_status_tracker_if #(.np(NP), .nv(NV), .buf_len(BL)) bus ();
    lag_pl_status_tracker #(.np(NP), .nv(NV), .buf_len(BL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [NP-1:0][NV-1:0]         status;
        logic [NP-1:0][NV-1:0]         avail;
        logic [NP-1:0][NV-1:0][CW-1:0] cnt;
        logic                          err;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_pass = 0;

    // pending stimulus for the next cycle
    logic [NP-1:0][NV-1:0] s_alloc, s_pl, s_cr;
    logic [NP-1:0]         s_valid, s_tail;
    logic                  s_rst;

    // reference model: integer credits, busy/draining flags per PL
    int m_cnt [NP][NV];
    bit m_busy[NP][NV];
    bit m_drain[NP][NV];
    bit m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_stim();
        s_alloc = '0; s_pl = '0; s_cr = '0; s_valid = '0; s_tail = '0; s_rst = 1'b1;
    endtask

    task automatic model_step();
        exp_t e;
        if (!s_rst) begin
            m_err = 0;
            foreach (m_cnt[p, v]) begin
                m_cnt[p][v] = BL; m_busy[p][v] = 0; m_drain[p][v] = 0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (s_valid[p] && $countones(s_pl[p]) > 1) m_err = 1;
                for (int v = 0; v < NV; v++) begin
                    bit snd, tl, cr, al;
                    int nc;
                    snd = s_valid[p] & s_pl[p][v];
                    tl  = snd & s_tail[p];
                    cr  = s_cr[p][v];
                    al  = s_alloc[p][v];
                    nc  = m_cnt[p][v] + int'(cr) - int'(snd);
                    if (nc < 0) begin nc = 0; m_err = 1; end
                    if (cr && m_cnt[p][v] == BL) m_err = 1;
                    if (nc > BL) nc = BL;
                    if (!m_busy[p][v]) begin
                        if (snd) m_err = 1;
                        if (al) begin m_busy[p][v] = 1; m_drain[p][v] = 0; end
                    end else begin
                        if (al) m_err = 1;
                        if (m_drain[p][v] && snd) m_err = 1;
                        if (!m_drain[p][v] && tl) m_drain[p][v] = 1;
                        if (m_drain[p][v] && nc == BL) m_busy[p][v] = 0;
                    end
                    m_cnt[p][v] = nc;
                end
            end
        end
        foreach (m_cnt[p, v]) begin
            e.status[p][v] = !m_busy[p][v];
            e.avail[p][v]  = (m_cnt[p][v] != 0);
            e.cnt[p][v]    = CW'(m_cnt[p][v]);
        end
        e.err = m_err;
        sbq.push_back(e);
    endtask

    task automatic tick();
        bus.pl_allocated    = s_alloc;
        bus.flit_sent_valid = s_valid;
        bus.flit_sent_pl    = s_pl;
        bus.flit_sent_tail  = s_tail;
        bus.credit_in       = s_cr;
        rst_n               = s_rst;
        @(posedge clk);
        model_step();
        #1;
        clear_stim();
    endtask

    task automatic snd(input int p, input int v, input bit t);
        s_valid[p] = 1'b1; s_pl[p][v] = 1'b1; s_tail[p] = t;
    endtask

    task automatic do_reset();
        s_rst = 1'b0; tick();
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("status", 64'(bus.pl_alloc_status), 64'(e.status));
            check("credit_avail", 64'(bus.credit_avail), 64'(e.avail));
            check("credit_cnt", 64'(bus.credit_cnt), 64'(e.cnt));
            check("error", 64'(bus.error), 64'(e.err));
        end
    end

    initial begin
        clear_stim();
        do_reset(); do_reset();

        // multi-flit packet on (1,2), drained by three credits
        s_alloc[1][2] = 1'b1; tick();
        snd(1, 2, 0); tick();
        snd(1, 2, 0); tick();
        snd(1, 2, 1); tick();
        repeat (3) begin s_cr[1][2] = 1'b1; tick(); end
        tick();

        // single-flit packet on (0,0) with a spurious credit alongside the tail
        do_reset();
        s_alloc[0][0] = 1'b1; tick();
        snd(0, 0, 1); s_cr[0][0] = 1'b1; tick();
        tick();

        // exhaust (3,1) then underflow; error stays sticky
        do_reset();
        s_alloc[3][1] = 1'b1; tick();
        repeat (5) begin snd(3, 1, 0); tick(); end
        repeat (3) tick();

        // balanced send + credit on (2,3) at cnt = 2
        do_reset();
        s_alloc[2][3] = 1'b1; tick();
        repeat (2) begin snd(2, 3, 0); tick(); end
        repeat (5) begin snd(2, 3, 0); s_cr[2][3] = 1'b1; tick(); end

        // double allocation on (4,0), then reset mid-packet with a send pending
        do_reset();
        s_alloc[4][0] = 1'b1; tick();
        tick();
        s_alloc[4][0] = 1'b1; tick();
        snd(4, 0, 0); tick();
        snd(4, 0, 0); s_rst = 1'b0; tick();
        tick();

        // multi-hot select on port 2
        do_reset();
        s_alloc[2][0] = 1'b1; s_alloc[2][1] = 1'b1; tick();
        s_valid[2] = 1'b1; s_pl[2][0] = 1'b1; s_pl[2][1] = 1'b1; tick();
        tick();

        // randomized traffic, mostly legal, reset periodically
        for (int c = 0; c < 600; c++) begin
            if (c % 120 == 0) begin
                s_rst = 1'b0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    for (int v = 0; v < NV; v++) begin
                        if (!m_busy[p][v] && $urandom_range(0, 7) == 0) s_alloc[p][v] = 1'b1;
                        else if ($urandom_range(0, 199) == 0) s_alloc[p][v] = 1'b1;
                        if (m_cnt[p][v] < BL && $urandom_range(0, 3) == 0) s_cr[p][v] = 1'b1;
                        else if ($urandom_range(0, 99) == 0) s_cr[p][v] = 1'b1;
                    end
                    if ($urandom_range(0, 2) == 0) begin
                        int v;
                        v = $urandom_range(0, NV - 1);
                        snd(p, v, $urandom_range(0, 3) == 0);
                        if ($urandom_range(0, 29) == 0) s_pl[p][(v + 1) % NV] = 1'b1;
                    end
                end
            end
            tick();
        end

        clear_stim(); tick();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
